// File: rtl/alu_bitserial_seq.sv
// alu_bitserial_seq: bit-serial WIDTH-bit ALU, one bit position per clock, LSB first, valid/ready on both sides
// Define ALU_SEQ_ZERO_FLAG_EN to add a registered Zero flag alongside Result.
module alu_bitserial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             out_valid,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic             Zero,
`endif
    input  logic             out_ready
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a, b, sh, res_n;
    logic [2:0] op;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic c, ab, bb, bs, r, c_n, co_n, last, take, arith;
    always_comb begin
        ab = a[cnt];
        bb = b[cnt];
        arith = (op == 3'b000) || (op == 3'b001);
        bs = (op == 3'b001) ? ~bb : bb;
        c_n = (ab & bs) | (ab & c) | (bs & c);
        acc_n = bb ? acc + ({{WIDTH{1'b0}}, a} << cnt) : acc;
        r = arith ? ab ^ bs ^ c :
            (op == 3'b011) ? ab & bb :
            (op == 3'b100) ? ab | bb :
            (op == 3'b101) ? ab ^ bb : 1'b0;
        res_n = (op == 3'b010) ? acc_n[WIDTH-1:0] : {r, sh[WIDTH-1:1]};
        co_n = arith ? c_n : (op == 3'b010) ? |acc_n[2*WIDTH-1:WIDTH] : 1'b0;
        last = cnt == CW'(WIDTH-1);
        in_ready = (state == IDLE) && !rst;
        out_valid = state == DONE;
        take = in_valid && in_ready;
        state_n = (state == IDLE && take) ? RUN :
                  (state == RUN && last) ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // Result is loaded only on the final bit so the port never shows partial sums.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a <= '0;
            b <= '0;
            op <= '0;
            cnt <= '0;
            c <= 1'b0;
            acc <= '0;
            sh <= '0;
            Result <= '0;
            CarryOut <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            Zero <= 1'b0;
`endif
        end else if (take) begin
            a <= A;
            b <= B;
            op <= Op;
            cnt <= '0;
            c <= Op == 3'b001;
            acc <= '0;
            sh <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            c <= c_n;
            acc <= acc_n;
            sh <= {r, sh[WIDTH-1:1]};
            if (last) begin
                Result <= res_n;
                CarryOut <= co_n;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                Zero <= res_n == '0;
`endif
            end
        end
endmodule
